// File: rtl/isa_pkg.sv
// Shared loader definitions: byte/word widths and the loader FSM states.
package isa_pkg;

  localparam int BYTE_W      = 8;
  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADR_HI,
    S_ADR_LO,
    S_CNT_HI,
    S_CNT_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_CHK
  } ld_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, status and instruction memory write port of the loader.
interface imem_loader_if
  import isa_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
);
  logic              start;
  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_adr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_adr, wr_data,
    output busy, done, err
  );

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_adr, wr_data,
    input  busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: assembles 16-bit words high byte
// first and writes them to consecutive instruction memory addresses.
module imem_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input logic clk,
  input logic rst_n,
  imem_loader_if.slave ld
);

  localparam int HW = 2 * BYTE_W;

  ld_state_e         state;
  ld_state_e         state_nxt;
  logic [HW-1:0]     adr;
  logic [HW-1:0]     cnt;
  logic [BYTE_W-1:0] hi;
  logic [BYTE_W-1:0] sum;
  logic              acc;
  logic [HW-1:0]     cnt_hdr;

  assign acc     = ld.in_valid && ld.in_ready;
  assign cnt_hdr = {cnt[HW-1:BYTE_W], ld.in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (ld.start) state_nxt = S_ADR_HI;
      S_ADR_HI: if (acc) state_nxt = S_ADR_LO;
      S_ADR_LO: if (acc) state_nxt = S_CNT_HI;
      S_CNT_HI: if (acc) state_nxt = S_CNT_LO;
      S_CNT_LO: if (acc) begin
        state_nxt = (cnt_hdr == '0) ? S_CHK : S_DAT_HI;
      end
      S_DAT_HI: if (acc) state_nxt = S_DAT_LO;
      S_DAT_LO: if (acc) begin
        state_nxt = (cnt == HW'(1)) ? S_CHK : S_DAT_HI;
      end
      S_CHK:    if (acc) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr         <= '0;
      cnt         <= '0;
      hi          <= '0;
      sum         <= '0;
      ld.in_ready <= 1'b0;
      ld.busy     <= 1'b0;
      ld.wr_en    <= 1'b0;
      ld.wr_adr   <= '0;
      ld.wr_data  <= '0;
      ld.done     <= 1'b0;
      ld.err      <= 1'b0;
    end else begin
      ld.wr_en    <= 1'b0;
      ld.done     <= 1'b0;
      ld.in_ready <= (state_nxt != S_IDLE);
      ld.busy     <= (state_nxt != S_IDLE);
      if (state == S_IDLE && ld.start) begin
        ld.err <= 1'b0;
        sum    <= '0;
      end
      // checksum covers every byte except the CHK byte itself
      if (acc && state != S_CHK) sum <= sum ^ ld.in_data;
      if (acc) begin
        unique case (state)
          S_ADR_HI: adr[HW-1:BYTE_W]  <= ld.in_data;
          S_ADR_LO: adr[BYTE_W-1:0]   <= ld.in_data;
          S_CNT_HI: cnt[HW-1:BYTE_W]  <= ld.in_data;
          S_CNT_LO: cnt[BYTE_W-1:0]   <= ld.in_data;
          S_DAT_HI: hi <= ld.in_data;
          S_DAT_LO: begin
            ld.wr_en   <= 1'b1;
            ld.wr_adr  <= ADDR_W'(adr);
            ld.wr_data <= DATA_W'({hi, ld.in_data});
            adr        <= adr + HW'(1);
            cnt        <= cnt - HW'(1);
          end
          S_CHK: begin
            ld.done <= 1'b1;
            ld.err  <= (ld.in_data != sum);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frame table plus corner sequences.
module tb_imem_loader;
  import isa_pkg::*;

  typedef struct {
    logic [127:0] raw;
    int           n;
    bit           exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [31:0] q[$];
  vec_t vt[5];

  imem_loader_if ld();

  imem_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ld.wr_en) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected: got %h/%h expected none",
                 ld.wr_adr, ld.wr_data);
      end else begin
        logic [31:0] e;
        e = q.pop_front();
        if ({ld.wr_adr, ld.wr_data} !== e) begin
          bad++;
          $display("FAIL wr: got %h/%h expected %h/%h",
                   ld.wr_adr, ld.wr_data, e[31:16], e[15:0]);
        end
      end
    end
  end

  function automatic logic [7:0] byte_at(vec_t v, int i);
    return v.raw[8*(v.n-1-i) +: 8];
  endfunction

  task automatic push_model(vec_t v);
    logic [15:0] a;
    logic [15:0] c;
    a = {byte_at(v, 0), byte_at(v, 1)};
    c = {byte_at(v, 2), byte_at(v, 3)};
    for (int k = 0; k < int'(c); k++) begin
      q.push_back({a, byte_at(v, 4 + 2*k), byte_at(v, 5 + 2*k)});
      a = a + 16'd1;
    end
  endtask

  task automatic pulse_start();
    ld.start = 1'b1;
    @(posedge clk); #1;
    ld.start = 1'b0;
  endtask

  task automatic send(logic [7:0] b, bit gaps);
    if (gaps) begin
      int g;
      g = $urandom_range(0, 3);
      for (int j = 0; j < g; j++) begin
        ld.in_valid = 1'b0;
        ld.start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        ld.start = 1'b0;
      end
    end
    ld.in_valid = 1'b1;
    ld.in_data = b;
    check("in_ready", 32'(ld.in_ready), 32'd1);
    @(posedge clk); #1;
    ld.in_valid = 1'b0;
  endtask

  task automatic run_frame(vec_t v, bit gaps, bit do_start);
    push_model(v);
    if (do_start) pulse_start();
    for (int i = 0; i < v.n; i++) send(byte_at(v, i), gaps);
    @(negedge clk);
    check("done", 32'(ld.done), 32'd1);
    check("busy_end", 32'(ld.busy), 32'd0);
    check("err", 32'(ld.err), 32'(v.exp_err));
    @(negedge clk);
    check("done_once", 32'(ld.done), 32'd0);
    check("q_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{72'h00_10_00_02_12_34_AB_CD_52, 9, 1'b0};
    vt[1] = '{72'hFF_FF_00_02_00_01_00_02_01, 9, 1'b0};
    vt[2] = '{40'h00_00_00_00_00, 5, 1'b0};
    vt[3] = '{56'h12_34_00_01_DE_AD_54, 7, 1'b0};
    vt[4] = '{72'h00_10_00_02_12_34_AB_CD_53, 9, 1'b1};

    ld.start = 1'b0;
    ld.in_valid = 1'b0;
    ld.in_data = '0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_in_ready", 32'(ld.in_ready), 32'd0);
    check("rst_wr_en", 32'(ld.wr_en), 32'd0);
    check("rst_wr_adr", 32'(ld.wr_adr), 32'd0);
    check("rst_wr_data", 32'(ld.wr_data), 32'd0);
    check("rst_busy", 32'(ld.busy), 32'd0);
    check("rst_done", 32'(ld.done), 32'd0);
    check("rst_err", 32'(ld.err), 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_frame(vt[i], 1'b0, 1'b1);

    // bad checksum is sticky until the next start
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(ld.err), 32'd1);
    @(posedge clk); #1;
    pulse_start();
    check("err_clr", 32'(ld.err), 32'd0);
    check("busy_rise", 32'(ld.busy), 32'd1);
    run_frame(vt[0], 1'b0, 1'b0);

    // stalled stream with stray start pulses
    @(posedge clk); #1;
    run_frame(vt[0], 1'b1, 1'b1);
    run_frame(vt[1], 1'b1, 1'b1);

    // in_valid in IDLE is ignored
    @(posedge clk); #1;
    ld.in_valid = 1'b1;
    ld.in_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_in_ready", 32'(ld.in_ready), 32'd0);
      check("idle_busy", 32'(ld.busy), 32'd0);
    end
    ld.in_valid = 1'b0;
    run_frame(vt[3], 1'b0, 1'b1);

    // reset right after the first data word is written
    @(posedge clk); #1;
    q.push_back({16'h0010, 16'h1234});
    pulse_start();
    for (int i = 0; i < 6; i++) send(byte_at(vt[0], i), 1'b0);
    @(negedge clk);
    check("mid_wr_en", 32'(ld.wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_wr_en", 32'(ld.wr_en), 32'd0);
    check("arst_wr_adr", 32'(ld.wr_adr), 32'd0);
    check("arst_wr_data", 32'(ld.wr_data), 32'd0);
    check("arst_busy", 32'(ld.busy), 32'd0);
    check("arst_in_ready", 32'(ld.in_ready), 32'd0);
    check("arst_q", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame(vt[1], 1'b0, 1'b1);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
